// File: rtl/inst_decode_pipe.sv
// MIPS decode stage with valid/ready handshake, output register plus one skid entry, and sync flush.
// Optional one-cycle load-use interlock enabled by defining INST_DECODE_LOAD_USE_EN.
module inst_decode_pipe #(
  parameter int unsigned PC_W       = 30,
  parameter int unsigned IMM_W      = 32,
  parameter bit          ZEXT_LOGIC = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [31:0]      inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  pc_out,
  output logic [31:0]      inst_out,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       dst,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [IMM_W-1:0] imm,
  output logic [25:0]      target,
  output logic [1:0]       itype
);

  typedef enum logic [1:0] {
    IT_R = 2'b00,
    IT_I = 2'b01,
    IT_J = 2'b10
  } itype_e;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [31:0]      inst;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       dst;
    logic [4:0]       shamt;
    logic [5:0]       funct;
    logic [IMM_W-1:0] imm;
    logic [25:0]      target;
    itype_e           itype;
  } dec_t;

  function automatic dec_t decode(input logic [PC_W-1:0] pc, input logic [31:0] w);
    dec_t              d;
    logic [5:0]        op;
    logic signed [15:0] simm;
    op   = w[31:26];
    simm = w[15:0];
    d      = '0;
    d.pc   = pc;
    d.inst = w;
    if (op == 6'h00) begin
      d.itype = IT_R;
      d.rs    = w[25:21];
      d.rt    = w[20:16];
      d.dst   = w[15:11];
      d.shamt = w[10:6];
      d.funct = w[5:0];
    end else if (op == 6'h02 || op == 6'h03) begin
      d.itype  = IT_J;
      d.target = w[25:0];
      d.dst    = (op == 6'h03) ? 5'd31 : 5'd0;
    end else begin
      d.itype = IT_I;
      d.rs    = w[25:21];
      d.rt    = w[20:16];
      // Branches and stores write nothing; everything else, undefined ops included, writes rt.
      if (op inside {6'h01, [6'h04:6'h07], [6'h28:6'h2B]})
        d.dst = 5'd0;
      else
        d.dst = w[20:16];
      if (ZEXT_LOGIC && (op inside {[6'h0C:6'h0E]}))
        d.imm = IMM_W'(w[15:0]);
      else
        d.imm = IMM_W'(simm);
    end
    return d;
  endfunction

  dec_t head, skid, in_dec;
  logic head_v, skid_v;
  logic accept, fire, hazard;

  always_comb begin
    in_dec = decode(pc_in, inst);
  end

`ifdef INST_DECODE_LOAD_USE_EN
  logic [4:0] last_load_dst;

  assign hazard = head_v && (last_load_dst != 5'd0) &&
                  ((head.rs == last_load_dst) || (head.rt == last_load_dst));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_load_dst <= '0;
    else if (flush || hazard)
      last_load_dst <= '0;
    else if (fire)
      last_load_dst <= (head.inst[31:26] inside {[6'h20:6'h25]}) ? head.dst : 5'd0;
  end
`else
  assign hazard = 1'b0;
`endif

  assign in_ready  = ~skid_v;
  assign out_valid = head_v & ~hazard;
  assign fire      = out_valid & out_ready;
  assign accept    = in_valid & ~skid_v;

  // While the skid is full in_ready is low, so a drain never coincides with an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      head   <= '0;
      skid   <= '0;
    end else if (flush) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (fire) begin
        head   <= skid;
        skid_v <= 1'b0;
      end
    end else if (accept) begin
      if (!head_v || fire) begin
        head   <= in_dec;
        head_v <= 1'b1;
      end else begin
        skid   <= in_dec;
        skid_v <= 1'b1;
      end
    end else if (fire) begin
      head_v <= 1'b0;
    end
  end

  assign pc_out   = head.pc;
  assign inst_out = head.inst;
  assign opcode   = head.inst[31:26];
  assign rs       = head.rs;
  assign rt       = head.rt;
  assign dst      = head.dst;
  assign shamt    = head.shamt;
  assign funct    = head.funct;
  assign imm      = head.imm;
  assign target   = head.target;
  assign itype    = head.itype;

endmodule
